// File: rtl/memory_read.sv
// ---------------------------------------------------------------------------
// memory_read
//
// Purpose:
//   Turns a linear read request of 1..4 bytes into one or two TLB reads.
//   If the request crosses a 16-byte line, it is split. The first part reads
//   from the requested address up to the end of the line. The second part
//   reads the remaining bytes from the start of the next line. The two parts
//   are then merged into one little-endian word aligned at bit 0.
//
// Ports:
//   clk, rst_n              clock; asynchronous active-low reset
//   i_rd_reset              flush; outstanding TLB work still completes
//   i_read_do               request, held high until done or fault
//   i_read_cpl/lock/rmw     request attributes, forwarded to the TLB port
//   i_read_address/length   byte address and byte count (1..4)
//   o_read_done             one-cycle pulse when read data is loaded
//   o_read_data             merged read data, bit-0 aligned
//   o_read_page/ac_fault    fault indications (live OR sticky)
//   o_tlbread_*             request to the TLB
//   i_tlbread_*             TLB completion, faults and data
// ---------------------------------------------------------------------------
module memory_read (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_rd_reset,
    input  logic        i_read_do,
    input  logic [1:0]  i_read_cpl,
    input  logic [31:0] i_read_address,
    input  logic [2:0]  i_read_length,
    input  logic        i_read_lock,
    input  logic        i_read_rmw,
    output logic        o_read_done,
    output logic [31:0] o_read_data,
    output logic        o_read_page_fault,
    output logic        o_read_ac_fault,
    output logic        o_tlbread_do,
    input  logic        i_tlbread_done,
    input  logic        i_tlbread_page_fault,
    input  logic        i_tlbread_ac_fault,
    input  logic [31:0] i_tlbread_data,
    output logic [1:0]  o_tlbread_cpl,
    output logic [31:0] o_tlbread_address,
    output logic [2:0]  o_tlbread_length,
    output logic [2:0]  o_tlbread_length_full,
    output logic        o_tlbread_lock,
    output logic        o_tlbread_rmw
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FIRST_WAIT = 2'd1,
        SECOND     = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_reset_waiting;
    logic        r_page_flag;
    logic        r_ac_flag;
    logic [23:0] r_buffer;
    logic [2:0]  r_length_2;
    logic [31:0] r_address_2;
    logic [31:0] r_read_data;
    logic        r_read_done;
    logic        r_tlbread_do;

    logic [4:0]  w_left;
    logic [2:0]  w_length_1;
    logic [2:0]  w_length_2;
    logic [31:0] w_address_2;
    logic [23:0] w_first_bytes;
    logic [31:0] w_shifted;
    logic [31:0] w_merged;
    logic        w_tlb_fault;
    logic        w_any_fault;

    // The first part stops at the end of the 16-byte line.
    // If the line has fewer bytes left than requested, left is at most 3,
    // so it fits in the 3-bit length.
    assign w_left      = 5'd16 - {1'b0, i_read_address[3:0]};
    assign w_length_1  = ({2'b00, i_read_length} > w_left) ? w_left[2:0] : i_read_length;
    assign w_length_2  = i_read_length - w_length_1;
    assign w_address_2 = {i_read_address[31:4], 4'h0} + 32'd16;

    // Shifting the second-part data up by length_1 bytes moves TLB byte
    // (k - length_1) into byte lane k. The merge below relies on this.
    assign w_shifted   = i_tlbread_data << {w_length_1, 3'b000};

    always_comb begin
        w_first_bytes = '0;
        w_merged      = '0;
        for (int k = 0; k < 3; k++) begin
            if (3'(k) < w_length_1) begin
                w_first_bytes[k*8 +: 8] = i_tlbread_data[k*8 +: 8];
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < i_read_length) begin
                if (3'(k) < w_length_1) begin
                    w_merged[k*8 +: 8] = (k < 3) ? r_buffer[(k % 3)*8 +: 8] : 8'h00;
                end else begin
                    w_merged[k*8 +: 8] = w_shifted[k*8 +: 8];
                end
            end
        end
    end

    assign w_tlb_fault       = i_tlbread_page_fault | i_tlbread_ac_fault;
    assign o_read_page_fault = i_tlbread_page_fault | r_page_flag;
    assign o_read_ac_fault   = i_tlbread_ac_fault | r_ac_flag;
    assign w_any_fault       = o_read_page_fault | o_read_ac_fault;

    assign o_tlbread_cpl         = i_read_cpl;
    assign o_tlbread_lock        = i_read_lock;
    assign o_tlbread_rmw         = i_read_rmw;
    assign o_tlbread_length_full = i_read_length;
    assign o_tlbread_address     = (r_state == SECOND) ? r_address_2 : i_read_address;
    assign o_tlbread_length      = (r_state == SECOND) ? r_length_2  : w_length_1;

    assign o_read_done  = r_read_done;
    assign o_read_data  = r_read_data;
    assign o_tlbread_do = r_tlbread_do;

    // Main sequencer.
    // A flush (reset_waiting) does not abandon the TLB handshake. It only
    // suppresses the read_done pulse and the read_data load when the
    // handshake finishes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_reset_waiting <= 1'b0;
            r_page_flag     <= 1'b0;
            r_ac_flag       <= 1'b0;
            r_buffer        <= '0;
            r_length_2      <= '0;
            r_address_2     <= '0;
            r_read_data     <= '0;
            r_read_done     <= 1'b0;
            r_tlbread_do    <= 1'b0;
        end else begin
            r_read_done <= 1'b0;

            if (r_state == IDLE) begin
                r_reset_waiting <= 1'b0;
            end else if (i_rd_reset) begin
                r_reset_waiting <= 1'b1;
            end

            if (i_rd_reset) begin
                r_page_flag <= 1'b0;
            end else if (i_tlbread_page_fault && !r_reset_waiting) begin
                r_page_flag <= 1'b1;
            end

            if (i_rd_reset) begin
                r_ac_flag <= 1'b0;
            end else if (i_tlbread_ac_fault && !r_reset_waiting) begin
                r_ac_flag <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    r_length_2  <= w_length_2;
                    r_address_2 <= w_address_2;
                    // A new request is not accepted in the cycle read_done pulses.
                    // This gives the requester a cycle to drop read_do.
                    if (i_read_do && !i_rd_reset && !w_any_fault && !r_read_done) begin
                        r_tlbread_do <= 1'b1;
                        r_state      <= FIRST_WAIT;
                    end
                end
                FIRST_WAIT: begin
                    if (w_tlb_fault) begin
                        r_tlbread_do <= 1'b0;
                        r_state      <= IDLE;
                    end else if (i_tlbread_done) begin
                        if (r_length_2 != 3'd0) begin
                            r_buffer <= w_first_bytes;
                            r_state  <= SECOND;
                        end else begin
                            if (!r_reset_waiting) begin
                                r_read_data <= i_tlbread_data;
                                r_read_done <= 1'b1;
                            end
                            r_tlbread_do <= 1'b0;
                            r_state      <= IDLE;
                        end
                    end
                end
                SECOND: begin
                    if (w_tlb_fault) begin
                        r_tlbread_do <= 1'b0;
                        r_state      <= IDLE;
                    end else if (i_tlbread_done) begin
                        if (!r_reset_waiting) begin
                            r_read_data <= w_merged;
                            r_read_done <= 1'b1;
                        end
                        r_tlbread_do <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_tlbread_do <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

endmodule
